// File: rtl/rf_pkg.sv
// Shared constants for the register-file writeback arbiter.
package rf_pkg;

    localparam int   RF_DATA_W   = 32;
    localparam int   RF_ADDR_W   = 5;
    localparam int   RF_ZERO_REG = 0;

    // Requester ids, also the bit index of each source in req/grant vectors.
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. On a tie, the source that was not
// granted most recently wins. last_grant moves only on accepted transfers.
module rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       hold,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       last_grant
);

    // Grant at most one requester; nothing is granted during reset or hold.
    always_comb begin
        grant = 2'b00;
        if (!rst && !hold) begin
            if (req == 2'b11) begin
                if (last_grant == REQ_B) grant[REQ_A] = 1'b1;
                else                     grant[REQ_B] = 1'b1;
            end else begin
                grant = req;
            end
        end
    end

    // Remember which source completed the latest transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= REQ_B;
        end else if (accept) begin
            last_grant <= grant[REQ_B] ? REQ_B : REQ_A;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the reg_file write port between the EX (A) and MEM (B) writeback
// paths. The write command is registered, so reg_file commits one cycle
// after the handshake. Writes to register 0 are accepted but never issued.
// Optional forwarding ports are built when RF_BYPASS_EN is defined.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_wr,
    input  logic [DATA_W-1:0] a_wd,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_wr,
    input  logic [DATA_W-1:0] b_wd,
    output logic              b_ready,
`ifdef RF_BYPASS_EN
    input  logic [ADDR_W-1:0] PR1,
    input  logic [ADDR_W-1:0] PR2,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd1_data,
    output logic [DATA_W-1:0] fwd2_data,
`endif
    output logic              write,
    output logic [ADDR_W-1:0] WR,
    output logic [DATA_W-1:0] WD,
    output logic              last_grant
);

    logic [1:0]        grant;
    logic              accept;
    logic [ADDR_W-1:0] sel_wr;
    logic [DATA_W-1:0] sel_wd;

    rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        ({b_valid, a_valid}),
        .hold       (hold),
        .accept     (accept),
        .grant      (grant),
        .last_grant (last_grant)
    );

    // Ready follows the grant; a transfer is a granted, valid source.
    always_comb begin
        a_ready = grant[REQ_A];
        b_ready = grant[REQ_B];
        accept  = (a_valid && a_ready) || (b_valid && b_ready);
        sel_wr  = grant[REQ_B] ? b_wr : a_wr;
        sel_wd  = grant[REQ_B] ? b_wd : a_wd;
    end

    // Register the write command; register-0 transfers leave WR/WD untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write <= 1'b0;
            WR    <= '0;
            WD    <= '0;
        end else if (accept && (sel_wr != ADDR_W'(RF_ZERO_REG))) begin
            write <= 1'b1;
            WR    <= sel_wr;
            WD    <= sel_wd;
        end else begin
            write <= 1'b0;
        end
    end

`ifdef RF_BYPASS_EN
    // Forward the in-flight write to the read stage on an address match.
    always_comb begin
        fwd1_hit  = write && (WR == PR1) && (PR1 != ADDR_W'(RF_ZERO_REG));
        fwd2_hit  = write && (WR == PR2) && (PR2 != ADDR_W'(RF_ZERO_REG));
        fwd1_data = fwd1_hit ? WD : '0;
        fwd2_data = fwd2_hit ? WD : '0;
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter with a small reg_file model.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int DW = RF_DATA_W;
    localparam int AW = RF_ADDR_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          hold;
    logic          a_valid, b_valid;
    logic [AW-1:0] a_wr, b_wr;
    logic [DW-1:0] a_wd, b_wd;
    logic          a_ready, b_ready;
    logic          write;
    logic [AW-1:0] WR;
    logic [DW-1:0] WD;
    logic          last_grant;
`ifdef RF_BYPASS_EN
    logic [AW-1:0] PR1, PR2;
    logic          fwd1_hit, fwd2_hit;
    logic [DW-1:0] fwd1_data, fwd2_data;
`endif

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] rf [2**AW];

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .hold       (hold),
        .a_valid    (a_valid),
        .a_wr       (a_wr),
        .a_wd       (a_wd),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_wr       (b_wr),
        .b_wd       (b_wd),
        .b_ready    (b_ready),
`ifdef RF_BYPASS_EN
        .PR1        (PR1),
        .PR2        (PR2),
        .fwd1_hit   (fwd1_hit),
        .fwd2_hit   (fwd2_hit),
        .fwd1_data  (fwd1_data),
        .fwd2_data  (fwd2_data),
`endif
        .write      (write),
        .WR         (WR),
        .WD         (WD),
        .last_grant (last_grant)
    );

    // reg_file model: commits the registered command on the rising edge.
    always @(posedge clk) begin
        if (write) rf[WR] <= WD;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; hold = 1'b0;
        a_valid = 1'b1; a_wr = 5'd4; a_wd = 32'd7;
        b_valid = 1'b0; b_wr = '0; b_wd = '0;
        #1;
        checks++;
        if (write !== 1'b0 || WR !== '0 || WD !== '0 || last_grant !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: write=%b WR=%0d WD=%0d last_grant=%b expected 0 0 0 1",
                     write, WR, WD, last_grant);
        end
        checks++;
        if (a_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: a_ready=%b expected 0", a_ready);
        end
        tick(); tick();
        rst = 1'b0;
        #1;
        tick();
        checks++;
        if (write !== 1'b1 || WR !== 5'd4) begin
            failures++;
            $display("FAIL pre_reset_xfer: write=%b WR=%0d expected 1 4", write, WR);
        end
        // Assert reset in the middle of the cycle while the command is live.
        #2 rst = 1'b1;
        #1;
        checks++;
        if (write !== 1'b0 || WR !== '0 || WD !== '0 || last_grant !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: write=%b WR=%0d WD=%0d last_grant=%b expected 0 0 0 1",
                     write, WR, WD, last_grant);
        end
        a_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++;
        if (write !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: write=%b expected 0", write);
        end
    endtask

    task automatic test_single();
        a_valid = 1'b1; a_wr = 5'd4; a_wd = 32'd31;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_ready: a_ready=%b b_ready=%b expected 1 0", a_ready, b_ready);
        end
        tick();
        a_valid = 1'b0;
        checks++;
        if (write !== 1'b1 || WR !== 5'd4 || WD !== 32'd31 || last_grant !== 1'b0) begin
            failures++;
            $display("FAIL single_write: write=%b WR=%0d WD=%0d lg=%b expected 1 4 31 0",
                     write, WR, WD, last_grant);
        end
        tick();
        checks++;
        if (write !== 1'b0 || WR !== 5'd4 || WD !== 32'd31) begin
            failures++;
            $display("FAIL single_idle_hold: write=%b WR=%0d WD=%0d expected 0 4 31", write, WR, WD);
        end
        checks++;
        if (rf[4] !== 32'd31) begin
            failures++;
            $display("FAIL single_rf_read: rf[4]=%0d expected 31", rf[4]);
        end
    endtask

    task automatic test_contention();
        rst = 1'b1;
        a_valid = 1'b1; a_wr = 5'd10; a_wd = 32'd10;
        b_valid = 1'b1; b_wr = 5'd12; b_wd = 32'd12;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            failures++;
            $display("FAIL cont_first_grant: a_ready=%b b_ready=%b expected 1 0", a_ready, b_ready);
        end
        tick();
        a_valid = 1'b0;
        checks++;
        if (write !== 1'b1 || WR !== 5'd10 || WD !== 32'd10 || last_grant !== 1'b0) begin
            failures++;
            $display("FAIL cont_write_a: write=%b WR=%0d WD=%0d lg=%b expected 1 10 10 0",
                     write, WR, WD, last_grant);
        end
        tick();
        b_valid = 1'b0;
        checks++;
        if (write !== 1'b1 || WR !== 5'd12 || WD !== 32'd12 || last_grant !== 1'b1) begin
            failures++;
            $display("FAIL cont_write_b: write=%b WR=%0d WD=%0d lg=%b expected 1 12 12 1",
                     write, WR, WD, last_grant);
        end
        tick();
    endtask

    task automatic test_alternate();
        logic          exp_b;
        logic [AW-1:0] exp_wr;
        logic [DW-1:0] exp_wd;
        a_valid = 1'b1; a_wr = 5'd3; a_wd = 32'h0000_A0A0;
        b_valid = 1'b1; b_wr = 5'd7; b_wd = 32'h0000_B0B0;
        for (int i = 0; i < 6; i++) begin
            exp_b  = (i % 2 == 1);
            exp_wr = exp_b ? 5'd7 : 5'd3;
            exp_wd = exp_b ? 32'h0000_B0B0 : 32'h0000_A0A0;
            #1;
            checks++;
            if (a_ready !== ~exp_b || b_ready !== exp_b) begin
                failures++;
                $display("FAIL alt_grant[%0d]: a_ready=%b b_ready=%b expected %b %b",
                         i, a_ready, b_ready, ~exp_b, exp_b);
            end
            tick();
            checks++;
            if (write !== 1'b1 || WR !== exp_wr || WD !== exp_wd || last_grant !== exp_b) begin
                failures++;
                $display("FAIL alt_write[%0d]: write=%b WR=%0d WD=%h lg=%b expected 1 %0d %h %b",
                         i, write, WR, WD, last_grant, exp_wr, exp_wd, exp_b);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        checks++;
        if (write !== 1'b0 || last_grant !== 1'b1) begin
            failures++;
            $display("FAIL alt_drain: write=%b lg=%b expected 0 1", write, last_grant);
        end
    endtask

    task automatic test_hold_zero();
        hold = 1'b1;
        b_valid = 1'b1; b_wr = 5'd1; b_wd = 32'd20;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (b_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_ready[%0d]: b_ready=%b expected 0", i, b_ready);
            end
            tick();
            checks++;
            if (write !== 1'b0) begin
                failures++;
                $display("FAIL hold_write[%0d]: write=%b expected 0", i, write);
            end
        end
        hold = 1'b0;
        #1;
        checks++;
        if (b_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release_ready: b_ready=%b expected 1", b_ready);
        end
        tick();
        b_valid = 1'b0;
        checks++;
        if (write !== 1'b1 || WR !== 5'd1 || WD !== 32'd20 || last_grant !== 1'b1) begin
            failures++;
            $display("FAIL hold_release_write: write=%b WR=%0d WD=%0d lg=%b expected 1 1 20 1",
                     write, WR, WD, last_grant);
        end
`ifdef RF_BYPASS_EN
        PR1 = 5'd1; PR2 = 5'd0;
        #1;
        checks++;
        if (fwd1_hit !== 1'b1 || fwd1_data !== 32'd20 || fwd2_hit !== 1'b0 || fwd2_data !== '0) begin
            failures++;
            $display("FAIL bypass: hit1=%b d1=%0d hit2=%b d2=%0d expected 1 20 0 0",
                     fwd1_hit, fwd1_data, fwd2_hit, fwd2_data);
        end
`endif
        a_valid = 1'b1; a_wr = 5'd0; a_wd = 32'd99;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            failures++;
            $display("FAIL zero_ready: a_ready=%b expected 1", a_ready);
        end
        tick();
        a_valid = 1'b0;
        checks++;
        if (write !== 1'b0 || last_grant !== 1'b0) begin
            failures++;
            $display("FAIL zero_drop: write=%b lg=%b expected 0 0", write, last_grant);
        end
    endtask

    task automatic test_collision();
        // last_grant is A here, so B is served first and A's data persists.
        a_valid = 1'b1; a_wr = 5'd9; a_wd = 32'd111;
        b_valid = 1'b1; b_wr = 5'd9; b_wd = 32'd222;
        tick();
        b_valid = 1'b0;
        checks++;
        if (write !== 1'b1 || WD !== 32'd222) begin
            failures++;
            $display("FAIL coll_first: write=%b WD=%0d expected 1 222", write, WD);
        end
        tick();
        a_valid = 1'b0;
        tick();
        checks++;
        if (rf[9] !== 32'd111) begin
            failures++;
            $display("FAIL coll_final: rf[9]=%0d expected 111", rf[9]);
        end
    endtask

    initial begin
`ifdef RF_BYPASS_EN
        PR1 = '0; PR2 = '0;
`endif
        test_reset();
        test_single();
        test_contention();
        test_alternate();
        test_hold_zero();
        test_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
